// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-state control unit for the CPU datapath.
// Enables, selects, memory strobes and ALU op come from state, IR opcode and CON_FF.
module control_sequencer #(
  parameter int OPW      = 5,
  parameter int MEM_WAIT = 1
) (
  input  logic           clock,
  input  logic           clear,
  input  logic           Stop,
  input  logic [31:0]    IR_data,
  input  logic           con_ff_bit,
  output logic           Run,
  output logic           IRin,
  output logic           PCin,
  output logic           RYin,
  output logic           RZin,
  output logic           MARin,
  output logic           MDRin,
  output logic           HIin,
  output logic           LOin,
  output logic           Outport_in,
  output logic           HIout,
  output logic           LOout,
  output logic           Zhi_out,
  output logic           Zlo_out,
  output logic           PCout,
  output logic           MDRout,
  output logic           Inport_out,
  output logic           Cout,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           CONin,
  output logic           Mem_read,
  output logic           Mem_write,
  output logic           IncPC,
  output logic [OPW-1:0] opcode
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  localparam int WW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(MEM_WAIT - 1);

  localparam logic [OPW-1:0] OP_LD   = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(11);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(15);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(16);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
  localparam logic [OPW-1:0] OP_BRX  = OPW'(19);
  localparam logic [OPW-1:0] OP_JR   = OPW'(20);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(21);
  localparam logic [OPW-1:0] OP_IN   = OPW'(22);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(23);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(24);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(25);
  localparam logic [OPW-1:0] OP_HALT = OPW'(27);

  state_e        state_q, state_d, nxt;
  logic [WW-1:0] wait_q, wait_d;
  logic          stop_q, stop_d;
  logic          mem_last, last, addr, hold;
  logic          t3, t4, t5, t6, t7;
  logic [OPW-1:0] op;
  logic          c_rr, c_md, c_un, c_imm, c_mem, c_brx;
  logic          c_jr, c_jal, c_in, c_out, c_mfhi, c_mflo;
  logic          unused_ir;

  assign op        = IR_data[31 -: OPW];
  assign unused_ir = ^IR_data[31-OPW:0];
  assign mem_last  = (wait_q == W_LAST);

  assign t3 = (state_q == S_T3);
  assign t4 = (state_q == S_T4);
  assign t5 = (state_q == S_T5);
  assign t6 = (state_q == S_T6);
  assign t7 = (state_q == S_T7);

  assign c_md   = (op == OP_DIV) || (op == OP_MUL);
  assign c_un   = (op == OP_NEG) || (op == OP_NOT);
  assign c_rr   = ((op >= OP_ADD) && (op <= OP_SHL)) ||
                  ((op >= OP_DIV) && (op <= OP_NOT));
  assign c_imm  = (op >= OP_ADDI) && (op <= OP_ORI);
  assign c_mem  = (op <= OP_ST);
  assign c_brx  = (op == OP_BRX);
  assign c_jr   = (op == OP_JR);
  assign c_jal  = (op == OP_JAL);
  assign c_in   = (op == OP_IN);
  assign c_out  = (op == OP_OUT);
  assign c_mfhi = (op == OP_MFHI);
  assign c_mflo = (op == OP_MFLO);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_RESET;
      wait_q  <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    unique case (state_q)
      S_T3:    nxt = S_T4;
      S_T4:    nxt = S_T5;
      S_T5:    nxt = S_T6;
      S_T6:    nxt = S_T7;
      default: nxt = S_T0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stop_d  = stop_q | Stop;
    Run = 1'b0; IRin = 1'b0; PCin = 1'b0; RYin = 1'b0;
    RZin = 1'b0; MARin = 1'b0; MDRin = 1'b0; HIin = 1'b0;
    LOin = 1'b0; Outport_in = 1'b0; HIout = 1'b0; LOout = 1'b0;
    Zhi_out = 1'b0; Zlo_out = 1'b0; PCout = 1'b0; MDRout = 1'b0;
    Inport_out = 1'b0; Cout = 1'b0; Gra = 1'b0; Grb = 1'b0;
    Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    CONin = 1'b0; Mem_read = 1'b0; Mem_write = 1'b0; IncPC = 1'b0;
    opcode = '0;
    last = 1'b0;
    addr = 1'b0;
    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      S_T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1;
        IncPC = 1'b1; RZin = 1'b1; opcode = OP_ADD;
        state_d = S_T1;
      end
      S_T1: begin
        Run = 1'b1; Zlo_out = 1'b1; PCin = 1'b1;
        Mem_read = 1'b1; MDRin = mem_last;
        state_d = S_T2;
      end
      S_T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      default: begin
        Run = 1'b1;
        unique case (1'b1)
          c_rr: begin
            Grb = t3 | (t4 & c_un); Grc = t4 & ~c_un;
            Rout = t3 | t4; RYin = t3; RZin = t4;
            Zlo_out = t5; Gra = t5 & ~c_md; Rin = t5 & ~c_md;
            LOin = t5 & c_md; Zhi_out = t6 & c_md; HIin = t6 & c_md;
            last = c_md ? t6 : t5;
          end
          c_imm: begin
            Grb = t3; Rout = t3; RYin = t3; Cout = t4; RZin = t4;
            Zlo_out = t5; Gra = t5; Rin = t5; last = t5;
          end
          c_mem: begin
            Grb = t3; BAout = t3; RYin = t3;
            Cout = t4; RZin = t4; addr = t4; Zlo_out = t5;
            if (op == OP_LDI) begin
              Gra = t5; Rin = t5; last = t5;
            end else if (op == OP_LD) begin
              MARin = t5; Mem_read = t6; MDRin = t6 & mem_last;
              MDRout = t7; Gra = t7; Rin = t7; last = t7;
            end else begin
              MARin = t5; Gra = t6; Rout = t6; MDRin = t6;
              Mem_write = t7; last = t7;
            end
          end
          c_brx: begin
            Gra = t3; Rout = t3; CONin = t3; PCout = t4; RYin = t4;
            Cout = t5; RZin = t5; addr = t5;
            Zlo_out = t6 & con_ff_bit; PCin = t6 & con_ff_bit;
            last = t6;
          end
          c_jr: begin
            Gra = t3; Rout = t3; PCin = t3; last = t3;
          end
          c_jal: begin
            PCout = t3; Grb = t3; Rin = t3;
            Gra = t4; Rout = t4; PCin = t4; last = t4;
          end
          c_in: begin
            Inport_out = t3; Gra = t3; Rin = t3; last = t3;
          end
          c_out: begin
            Gra = t3; Rout = t3; Outport_in = t3; last = t3;
          end
          c_mfhi: begin
            HIout = t3; Gra = t3; Rin = t3; last = t3;
          end
          c_mflo: begin
            LOout = t3; Gra = t3; Rin = t3; last = t3;
          end
          default: last = t3;
        endcase
        last   = last | t7;
        opcode = addr ? OP_ADD : op;
        if (last) state_d = (op == OP_HALT || stop_d) ? S_HALT : S_T0;
        else      state_d = nxt;
      end
    endcase
    // Memory strobes stretch their state until the wait count expires.
    hold = (Mem_read | Mem_write) & ~mem_last;
    if (hold) state_d = state_q;
    wait_d = hold ? wait_q + 1'b1 : '0;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: two DUTs (MEM_WAIT 1 and 3) checked cycle by cycle
// against per-instruction step lists built from the instruction set rules.
module tb_control_sequencer;

  localparam logic [27:0] RUN  = 28'h1 << 27;
  localparam logic [27:0] IRI  = 28'h1 << 26;
  localparam logic [27:0] PCI  = 28'h1 << 25;
  localparam logic [27:0] RYI  = 28'h1 << 24;
  localparam logic [27:0] RZI  = 28'h1 << 23;
  localparam logic [27:0] MARI = 28'h1 << 22;
  localparam logic [27:0] MDRI = 28'h1 << 21;
  localparam logic [27:0] HII  = 28'h1 << 20;
  localparam logic [27:0] LOI  = 28'h1 << 19;
  localparam logic [27:0] OUTP = 28'h1 << 18;
  localparam logic [27:0] HIO  = 28'h1 << 17;
  localparam logic [27:0] LOO  = 28'h1 << 16;
  localparam logic [27:0] ZHI  = 28'h1 << 15;
  localparam logic [27:0] ZLO  = 28'h1 << 14;
  localparam logic [27:0] PCO  = 28'h1 << 13;
  localparam logic [27:0] MDRO = 28'h1 << 12;
  localparam logic [27:0] INP  = 28'h1 << 11;
  localparam logic [27:0] COUT = 28'h1 << 10;
  localparam logic [27:0] GRA  = 28'h1 << 9;
  localparam logic [27:0] GRB  = 28'h1 << 8;
  localparam logic [27:0] GRC  = 28'h1 << 7;
  localparam logic [27:0] RIN  = 28'h1 << 6;
  localparam logic [27:0] ROUT = 28'h1 << 5;
  localparam logic [27:0] BAO  = 28'h1 << 4;
  localparam logic [27:0] CONI = 28'h1 << 3;
  localparam logic [27:0] MRD  = 28'h1 << 2;
  localparam logic [27:0] MWR  = 28'h1 << 1;
  localparam logic [27:0] INC  = 28'h1 << 0;
  localparam logic [4:0]  ADD  = 5'd3;

  logic        clock;
  logic        clear [2];
  logic        stop  [2];
  logic        con   [2];
  logic [31:0] ir    [2];
  logic [32:0] obs   [2];
  logic [32:0] exp_q [$];
  int          n_chk, n_fail;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [4:0] opc;
    logic run, iri, pci, ryi, rzi, mari, mdri, hii, loi, outpi;
    logic hio, loo, zhio, zloo, pco, mdro, inpo, cout;
    logic gra, grb, grc, rin, rout, bao, coni, mrd, mwr, incpc;
    control_sequencer #(.OPW(5), .MEM_WAIT(g == 0 ? 1 : 3)) u_dut (
      .clock(clock), .clear(clear[g]), .Stop(stop[g]),
      .IR_data(ir[g]), .con_ff_bit(con[g]),
      .Run(run), .IRin(iri), .PCin(pci), .RYin(ryi), .RZin(rzi),
      .MARin(mari), .MDRin(mdri), .HIin(hii), .LOin(loi),
      .Outport_in(outpi), .HIout(hio), .LOout(loo), .Zhi_out(zhio),
      .Zlo_out(zloo), .PCout(pco), .MDRout(mdro), .Inport_out(inpo),
      .Cout(cout), .Gra(gra), .Grb(grb), .Grc(grc), .Rin(rin),
      .Rout(rout), .BAout(bao), .CONin(coni), .Mem_read(mrd),
      .Mem_write(mwr), .IncPC(incpc), .opcode(opc)
    );
    assign obs[g] = {opc, run, iri, pci, ryi, rzi, mari, mdri, hii, loi,
                     outpi, hio, loo, zhio, zloo, pco, mdro, inpo, cout,
                     gra, grb, grc, rin, rout, bao, coni, mrd, mwr, incpc};
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [32:0] got,
                     input logic [32:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic push(input logic [4:0] opc, input logic [27:0] m);
    exp_q.push_back({opc, m | RUN});
  endtask

  // Expected control word for every cycle of one instruction.
  task automatic build(input int mw, input logic [4:0] op, input bit c);
    exp_q.delete();
    push(ADD, PCO | MARI | INC | RZI);
    for (int i = 0; i < mw; i++) push(5'd0, ZLO | PCI | MRD | ((i == mw - 1) ? MDRI : 28'h0));
    push(5'd0, MDRO | IRI);
    if ((op >= 3 && op <= 11) || (op >= 15 && op <= 18)) begin
      push(op, GRB | ROUT | RYI);
      push(op, ((op == 17 || op == 18) ? GRB : GRC) | ROUT | RZI);
      if (op == 15 || op == 16) begin
        push(op, ZLO | LOI);
        push(op, ZHI | HII);
      end else push(op, ZLO | GRA | RIN);
    end else if (op >= 12 && op <= 14) begin
      push(op, GRB | ROUT | RYI);
      push(op, COUT | RZI);
      push(op, ZLO | GRA | RIN);
    end else if (op <= 2) begin
      push(op, GRB | BAO | RYI);
      push(ADD, COUT | RZI);
      if (op == 1) push(op, ZLO | GRA | RIN);
      else begin
        push(op, ZLO | MARI);
        if (op == 0) begin
          for (int i = 0; i < mw; i++) push(op, MRD | ((i == mw - 1) ? MDRI : 28'h0));
          push(op, MDRO | GRA | RIN);
        end else begin
          push(op, GRA | ROUT | MDRI);
          for (int i = 0; i < mw; i++) push(op, MWR);
        end
      end
    end else begin
      case (op)
        5'd19: begin
          push(op, GRA | ROUT | CONI);
          push(op, PCO | RYI);
          push(ADD, COUT | RZI);
          push(op, c ? (ZLO | PCI) : 28'h0);
        end
        5'd20: push(op, GRA | ROUT | PCI);
        5'd21: begin
          push(op, PCO | GRB | RIN);
          push(op, GRA | ROUT | PCI);
        end
        5'd22: push(op, INP | GRA | RIN);
        5'd23: push(op, GRA | ROUT | OUTP);
        5'd24: push(op, HIO | GRA | RIN);
        5'd25: push(op, LOO | GRA | RIN);
        default: push(op, 28'h0);
      endcase
    end
  endtask

  task automatic bus_ok(input int d);
    logic [32:0] o;
    logic        ok;
    o  = obs[d];
    ok = ($countones({o[17:10], o[5:4]}) <= 1) && !(o[2] && o[1]);
    chk("bus_excl", {32'd0, ok}, 33'd1);
  endtask

  // Hold clear low for a cycle, release, return at the negedge showing T0.
  task automatic restart(input int d);
    clear[d] = 1'b0;
    stop[d]  = 1'b0;
    #1 chk("rst_async", obs[d], 33'd0);
    @(negedge clock);
    chk("rst_held", obs[d], 33'd0);
    clear[d] = 1'b1;
    #1 chk("rst_rel", obs[d], 33'd0);
    @(negedge clock);
  endtask

  task automatic run_ins(input int d, input logic [31:0] irw, input bit c,
                         input int stop_at, input int abort_at,
                         input string tag);
    int  n;
    bit  hlt;
    build(d == 0 ? 1 : 3, irw[31:27], c);
    n     = exp_q.size();
    hlt   = (irw[31:27] == 5'd27) || (stop_at >= 0 && stop_at < n);
    ir[d] = irw;
    con[d] = c;
    for (int i = 0; i < n; i++) begin
      stop[d] = (i == stop_at);
      #1 chk($sformatf("%s_c%0d", tag, i), obs[d], exp_q[i]);
      bus_ok(d);
      if (i == abort_at) begin
        #2 clear[d] = 1'b0;
        #1 chk($sformatf("%s_abort", tag), obs[d], 33'd0);
        restart(d);
        return;
      end
      @(negedge clock);
    end
    stop[d] = 1'b0;
    if (hlt) begin
      for (int k = 0; k < 20; k++) begin
        #1 chk($sformatf("%s_halt%0d", tag, k), obs[d], 33'd0);
        @(negedge clock);
      end
      restart(d);
    end
  endtask

  task automatic rand_run(input int d, input int cnt);
    logic [31:0] r;
    logic [4:0]  op;
    int          sa, ab;
    for (int k = 0; k < cnt; k++) begin
      r  = $urandom();
      op = 5'($urandom_range(0, 31));
      sa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_ins(d, {op, r[26:0]}, 1'($urandom_range(0, 1)), sa, ab,
              $sformatf("rnd%0d_op%0d", d, op));
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int d = 0; d < 2; d++) begin
      clear[d] = 1'b0;
      stop[d]  = 1'b0;
      con[d]   = 1'b0;
      ir[d]    = '0;
    end
    repeat (2) @(negedge clock);

    restart(0);
    run_ins(0, 32'h19888000, 1'b0, -1, -1, "add");
    run_ins(0, 32'h19888000, 1'b0, -1, 4, "add_rst_t4");
    run_ins(0, 32'h19888000, 1'b0, -1, -1, "add2");
    run_ins(0, 32'h81100000, 1'b0, -1, -1, "mul");
    run_ins(0, 32'h78900000, 1'b0, -1, -1, "div");
    run_ins(0, 32'h88900000, 1'b0, -1, -1, "neg");
    run_ins(0, 32'h98800010, 1'b0, -1, -1, "brx_nt");
    run_ins(0, 32'h98800010, 1'b1, -1, -1, "brx_t");
    run_ins(0, 32'h00900054, 1'b0, -1, -1, "ld1");
    run_ins(0, 32'hA8900000, 1'b0, -1, -1, "jal");
    run_ins(0, 32'hD0000000, 1'b0, -1, -1, "nop");
    run_ins(0, 32'h10900054, 1'b0, 4, -1, "st_stop");
    run_ins(0, 32'hD8000000, 1'b0, -1, -1, "halt");
    rand_run(0, 150);
    clear[0] = 1'b0;

    restart(1);
    run_ins(1, 32'h00900054, 1'b0, -1, -1, "ld3");
    run_ins(1, 32'h08900054, 1'b0, -1, -1, "ldi3");
    run_ins(1, 32'h19888000, 1'b0, -1, -1, "add3");
    run_ins(1, 32'h10900054, 1'b0, 6, -1, "st3_stop");
    run_ins(1, 32'h10900054, 1'b0, -1, 10, "st3_rst");
    run_ins(1, 32'hB8800000, 1'b0, -1, -1, "out3");
    rand_run(1, 150);
    clear[1] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
